// File: rtl/cordic_fixed_to_float.sv
// cordic_fixed_to_float
//   Output stage for the unrolled cosine CORDIC chain. It converts the
//   chain's signed Q2.WIDTH X result to IEEE-754 single precision, rounding
//   to nearest with ties to even. The conversion runs as a 3-stage
//   valid/ready pipeline. Each stage has its own valid bit, and bubbles
//   collapse.
//
//   Ports:
//     clk        system clock, rising edge
//     rst_n      asynchronous active-low reset
//     in_valid   in_fixed holds a sample
//     in_ready   stage can accept a sample this cycle
//     in_fixed   signed Q2.WIDTH value, WIDTH+2 bits
//     out_valid  out_float holds a result
//     out_ready  downstream accepts out_float this cycle
//     out_float  IEEE-754 single {sign, exponent[7:0], mantissa[22:0]}
module cordic_fixed_to_float #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH+1:0] in_fixed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_float
);

    localparam int unsigned IW = WIDTH + 2;   // input / magnitude width
    localparam int unsigned FW = WIDTH + 1;   // bits below the leading one
    localparam int unsigned PW = $clog2(IW);  // leading-one position width

    // Stage state
    logic          s1_valid, s2_valid, s3_valid;
    logic          s1_sign;
    logic [IW-1:0] s1_mag;
    logic          s2_sign, s2_zero;
    logic [PW-1:0] s2_lead;
    logic [FW-1:0] s2_frac;

    // Advance chain: a stage loads when it is empty or its contents move on.
    logic adv1, adv2, adv3;
    assign adv3     = !s3_valid || out_ready;
    assign adv2     = !s2_valid || adv3;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;
    assign out_valid = s3_valid;

    // S1 combinational: magnitude. The most negative input negates to
    // 2^(WIDTH+1), which still fits as an unsigned IW-bit value.
    logic [IW-1:0] mag_in;
    always_comb begin
        mag_in = in_fixed;
        if (in_fixed[IW-1]) begin
            mag_in = ~in_fixed + IW'(1);
        end
    end

    // S2 combinational: leading-one detect and normalise. The fraction keeps
    // only the bits below the leading one, left-aligned.
    logic [PW-1:0] lead_pos;
    logic [FW-1:0] frac_norm;
    logic          mag_zero;
    always_comb begin
        lead_pos = '0;
        for (int unsigned i = 0; i < IW; i++) begin
            if (s1_mag[i]) begin
                lead_pos = PW'(i);
            end
        end
        mag_zero  = (s1_mag == '0);
        frac_norm = FW'(s1_mag << (PW'(IW - 1) - lead_pos));
    end

    // S3 combinational: round to 23 bits and assemble the float. The
    // fraction is placed at the top of a 32-bit field. Bit 8 is then the
    // guard bit and bits 7:0 are sticky. When p <= 23 those bits are zero.
    logic [31:0] frac_ext;
    logic [22:0] mant_raw;
    logic        guard_bit, sticky_bit, round_up;
    logic [23:0] mant_sum;
    logic [7:0]  exp_field;
    logic [31:0] result;
    always_comb begin
        frac_ext            = '0;
        frac_ext[31 -: FW]  = s2_frac;
        mant_raw            = frac_ext[31:9];
        guard_bit           = frac_ext[8];
        sticky_bit          = |frac_ext[7:0];
        round_up            = guard_bit & (sticky_bit | mant_raw[0]);
        mant_sum            = {1'b0, mant_raw} + 24'(round_up);
        // A carry out of the mantissa leaves mant_sum[22:0] at zero and
        // bumps the exponent.
        exp_field           = 8'd127 + 8'(s2_lead) - 8'(WIDTH) + 8'(mant_sum[23]);
        result              = {s2_sign, exp_field, mant_sum[22:0]};
        if (s2_zero) begin
            result = '0;
        end
    end

    // Valid bits and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            out_float <= '0;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid;
            end
            if (adv2) begin
                s2_valid <= s1_valid;
            end
            if (adv3) begin
                s3_valid <= s2_valid;
                if (s2_valid) begin
                    out_float <= result;
                end
            end
        end
    end

    // Datapath registers (no reset needed)
    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            s1_sign <= in_fixed[IW-1];
            s1_mag  <= mag_in;
        end
        if (adv2 && s1_valid) begin
            s2_sign <= s1_sign;
            s2_zero <= mag_zero;
            s2_lead <= lead_pos;
            s2_frac <= frac_norm;
        end
    end

endmodule

// File: doc/cordic_fixed_to_float.md
Name: cordic_fixed_to_float

Overview:
- Pipelined output stage that sits directly downstream of the unrolled cosine CORDIC chain.
- Consumes the chain's signed fixed-point X result (Q2.WIDTH, WIDTH+2 bits) and returns an IEEE-754 single-precision result.
- Rounding is round-to-nearest-even.
- Adds valid/ready flow control and registers so the combinational CORDIC output can be timed and back-pressured by the downstream float consumer.

Parameters:
- WIDTH, 24, number of fractional bits of the fixed-point input; input width is WIDTH+2 (2 integer bits, two's complement). Legal range 8..28.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_fixed holds a sample.
- in_ready  output  1  stage can accept a sample this cycle.
- in_fixed  input  WIDTH+2  signed Q2.WIDTH value (CORDIC X output).
- out_valid  output  1  out_float holds a result.
- out_ready  input  1  downstream accepts out_float this cycle.
- out_float  output  32  IEEE-754 single: sign[31], exponent[30:23], mantissa[22:0].

Behaviour:
- Reset:
  - Clock is clk. Reset is asynchronous, active-low: rst_n low immediately clears all stage valid bits.
  - Outputs while reset is held: out_valid=0, out_float=32'h0, in_ready=1.
  - Datapath registers need not be reset, except out_float, which resets to 0.
- Transfers:
  - An input transfer occurs when in_valid and in_ready are both high at a clock edge.
  - An output transfer occurs when out_valid and out_ready are both high at a clock edge.
- Pipeline: 3 register stages, each with its own valid bit.
  - S1: capture sign and magnitude. mag = |in_fixed| in WIDTH+2 unsigned bits. -2^(WIDTH+1) gives mag = 2^(WIDTH+1) with no overflow.
  - S2: leading-one position p (0..WIDTH+1) and zero flag; normalise mag so the leading one sits at bit WIDTH+1.
  - S3: round, assemble the float, drive out_float and out_valid.
- Stage advance rule: stage k loads when it is empty or its contents leave this cycle. S3 leaves when out_ready=1. in_ready = (S1 empty) or (S1 advances). This rule collapses bubbles.
- Latency: 3 cycles from input transfer to out_valid, when there is no back-pressure. Throughput: 1 sample/cycle.
- Stall: with out_ready=0, out_float and out_valid hold stable. Up to 3 samples are buffered, after which in_ready=0. No sample is ever lost or duplicated.
- Arithmetic:
  - value = mag * 2^-WIDTH; exponent field = 127 + p - WIDTH.
  - If p <= 23: mantissa = bits below the leading one, left-aligned, zero-filled. Result is exact.
  - If p > 23: drop p-23 LSBs and round to nearest, ties to even.
  - Mantissa carry-out on rounding: mantissa=0, exponent+1.
  - Zero input gives 32'h00000000 (+0, never -0).
  - Results are never denormal, infinite or NaN for legal WIDTH.
- Simultaneous events: an input transfer and an output transfer in the same cycle are both honoured, and occupancy is unchanged.
- Reset mid-operation: all in-flight samples are discarded. The first output after rst_n deasserts comes only from an input accepted after the deassertion.
- Ordering: results appear strictly in input order.

Test Plan:
- in_fixed=26'h1000000 (1.0), out_ready=1 -> out_float=32'h3F800000 three cycles later, out_valid pulses 1 cycle.
- in_fixed=26'h09B74EE (CORDIC gain constant 0.60725) -> 32'h3F1B74EE. Same input with 26'h3000000 (-1.0) -> 32'hBF800000.
- Rounding and ties:
  - 26'h1000001 -> 32'h3F800000 (tie, even, round down).
  - 26'h1000003 -> 32'h3F800002 (tie, odd, round up).
  - 26'h1FFFFFF -> 32'h40000000 (carry into exponent).
- Extremes:
  - 26'h0000000 -> 32'h00000000.
  - 26'h0000001 -> 32'h33800000.
  - 26'h2000000 (-2.0) -> 32'hC0000000.
- Back-pressure:
  - Stream 10 distinct samples with in_valid=1 and out_ready=0 for cycles 2..8. in_ready must drop after 3 accepted.
  - All 10 outputs must then appear in order with none lost or duplicated.
  - out_float must be stable while stalled.
  - With out_ready=1 continuously, one result per cycle.
- Reset mid-operation: assert rst_n=0 with 3 samples in flight -> out_valid=0 and in_ready=1 immediately. After release, no stale output appears, and a new 1.0 input yields 32'h3F800000 after 3 cycles.
